// File: rtl/router_pkg.sv
// Shared constants, header field helpers and FSM state encoding for the router packet writer.
package router_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_DEST = 3;
    localparam int unsigned LEN_W    = 6;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_LEN_MSB  = 7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LFD,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK,
        DROP
    } state_t;

    function automatic logic [ADDR_W-1:0] hdr_addr_of(input logic [DATA_W-1:0] b);
        return b[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_len_of(input logic [DATA_W-1:0] b);
        return b[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; clear wins over load, load wins over accumulate.
module router_parity_acc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= din;
        end else if (acc_en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/router_pkt_writer.sv
// Ingress writer for the 1x3 router: header decode, FIFO write sequencing, parity check.
// Optional payload length check when ROUTER_LEN_CHECK_EN is defined.
module router_pkt_writer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_DEST = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [NUM_DEST-1:0] fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_rst,
    output logic [DATA_W-1:0]   dout,
    output logic [NUM_DEST-1:0] wr_en,
    output logic                lfd_state,
    output logic                busy,
    output logic [1:0]          addr_out,
    output logic                parity_done,
    output logic                err
);

    import router_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic                pend_valid;
    logic [DATA_W-1:0]   rx_parity;
    logic [DATA_W-1:0]   acc;
    logic [NUM_DEST-1:0] dest_oh;
    logic [NUM_DEST-1:0] hdr_oh;
    logic                sel_full;
    logic                sel_empty;
    logic                sel_srst;
    logic                hdr_empty;
    logic                stall;
    logic                write_go;
    logic                hdr_take;
    logic                ld_take;
    logic                pay_take;
    logic                abort;
    logic                len_bad;

    // The invalid address decodes to an all-zero select, so nothing is written or checked for it.
    always_comb begin
        dest_oh = '0;
        hdr_oh  = '0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            if (addr_out == ADDR_W'(i))              dest_oh[i] = 1'b1;
            if (hdr_addr_of(data_in) == ADDR_W'(i))  hdr_oh[i]  = 1'b1;
        end
    end

    assign sel_full  = |(fifo_full & dest_oh);
    assign sel_empty = |(fifo_empty & dest_oh);
    assign sel_srst  = |(soft_rst & dest_oh);
    assign hdr_empty = |(fifo_empty & hdr_oh);

    assign stall    = (state == LOAD_DATA) && pend_valid && sel_full;
    assign write_go = pend_valid && !sel_full && (state inside {LOAD_DATA, LOAD_PARITY});
    assign hdr_take = (state == IDLE) && pkt_valid;
    assign ld_take  = (state == LOAD_DATA) && !stall;
    assign pay_take = ld_take && pkt_valid && !sel_srst;
    assign abort    = sel_srst && (state inside {WAIT_EMPTY, LFD, LOAD_DATA, LOAD_PARITY});

    always_comb begin
        wr_en       = write_go ? dest_oh : '0;
        busy        = (state inside {WAIT_EMPTY, LFD, LOAD_PARITY, CHECK}) || stall;
        lfd_state   = (state == LFD);
        parity_done = (state == CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (hdr_addr_of(data_in) == ADDR_INVALID) state_nxt = DROP;
                    else if (hdr_empty)                       state_nxt = LFD;
                    else                                      state_nxt = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (sel_srst)       state_nxt = DROP;
                else if (sel_empty) state_nxt = LFD;
            end
            LFD: state_nxt = sel_srst ? DROP : LOAD_DATA;
            LOAD_DATA: begin
                // A parity byte taken in the abort cycle already ends the packet, so skip DROP.
                if (sel_srst)                    state_nxt = (ld_take && !pkt_valid) ? IDLE : DROP;
                else if (ld_take && !pkt_valid)  state_nxt = LOAD_PARITY;
            end
            LOAD_PARITY: begin
                if (sel_srst)      state_nxt = IDLE;
                else if (write_go) state_nxt = CHECK;
            end
            CHECK:   state_nxt = IDLE;
            DROP:    if (!pkt_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            addr_out   <= '0;
            pend_valid <= 1'b0;
            rx_parity  <= '0;
            err        <= 1'b0;
        end else begin
            if (hdr_take) begin
                dout       <= data_in;
                addr_out   <= hdr_addr_of(data_in);
                pend_valid <= (hdr_addr_of(data_in) != ADDR_INVALID);
                err        <= 1'b0;
            end else if (abort) begin
                pend_valid <= 1'b0;
            end else if (ld_take) begin
                dout       <= data_in;
                pend_valid <= 1'b1;
                if (!pkt_valid) rx_parity <= data_in;
            end else if ((state == LOAD_PARITY) && write_go) begin
                pend_valid <= 1'b0;
            end
            if (state == CHECK) err <= (acc != rx_parity) || len_bad;
        end
    end

    router_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (abort),
        .load   (hdr_take),
        .acc_en (pay_take),
        .din    (data_in),
        .acc    (acc)
    );

`ifdef ROUTER_LEN_CHECK_EN
    logic [LEN_W-1:0] pay_cnt;
    logic [LEN_W-1:0] hdr_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pay_cnt <= '0;
            hdr_len <= '0;
        end else if (hdr_take) begin
            pay_cnt <= '0;
            hdr_len <= hdr_len_of(data_in);
        end else if (pay_take) begin
            pay_cnt <= pay_cnt + 1'b1;
        end
    end

    assign len_bad = (pay_cnt != hdr_len);
`else
    assign len_bad = 1'b0;
`endif

endmodule
